// File: rtl/bus_hold_arbiter_if.sv
// Local-bus sharing signals between the HOLD/HLDA arbiter and its peers
// (processor HOLD/HLDA pins and the bus-master requesters).
interface bus_hold_arbiter_if #(
   parameter int unsigned NREQ = 2
);
   logic [NREQ-1:0] REQ;
   logic            HLDA;
   logic            HOLD;
   logic [NREQ-1:0] GNT;
   logic            BUS_OWNED;
   logic            PREEMPT;
   logic            ERR;

   modport master (
      input  REQ,
      input  HLDA,
      output HOLD,
      output GNT,
      output BUS_OWNED,
      output PREEMPT,
      output ERR
   );

   modport slave (
      output REQ,
      output HLDA,
      input  HOLD,
      input  GNT,
      input  BUS_OWNED,
      input  PREEMPT,
      input  ERR
   );
endinterface

// File: rtl/bus_hold_arbiter.sv
// bus_hold_arbiter: round-robin HOLD/HLDA arbiter that lends the 8088 local
// bus to NREQ bus masters for bounded bursts, then returns it to the CPU.
module bus_hold_arbiter #(
   parameter int unsigned NREQ         = 2,
   parameter int unsigned MAX_BURST    = 16,
   parameter int unsigned TURNAROUND   = 1,
   parameter int unsigned HLDA_TIMEOUT = 64
) (
   input logic                CLK,
   input logic                RESET_N,
   bus_hold_arbiter_if.master bus
);
   localparam int unsigned OW     = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int unsigned CMAX_A = (MAX_BURST > HLDA_TIMEOUT) ? MAX_BURST : HLDA_TIMEOUT;
   // The same counter also times the turnaround, so it must hold TURNAROUND-1 too
   localparam int unsigned CMAX   = (CMAX_A > TURNAROUND) ? CMAX_A : TURNAROUND;
   localparam int unsigned CW     = (CMAX > 1) ? $clog2(CMAX) : 1;

   localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);
   localparam logic [CW-1:0] TO_LAST    = CW'(HLDA_TIMEOUT - 1);
   localparam logic [CW-1:0] TA_LAST    = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HOLD_WAIT,
      S_GRANT,
      S_RELEASE,
      S_HLDA_WAIT
   } state_t;

   state_t          state_q, state_d;
   logic [OW-1:0]   owner_q, owner_d;
   logic [OW-1:0]   last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            hold_q, hold_d;
   logic [NREQ-1:0] gnt_q, gnt_d;
   logic            owned_q;
   logic            preempt_q, preempt_d;
   logic            err_q, err_d;
   logic [NREQ-1:0] req;
   logic            hlda;
   logic [OW-1:0]   sel;
   logic [OW-1:0]   cand;
   logic            found;
   logic            leave;

   assign req           = bus.REQ;
   assign hlda          = bus.HLDA;
   assign bus.HOLD      = hold_q;
   assign bus.GNT       = gnt_q;
   assign bus.BUS_OWNED = owned_q;
   assign bus.PREEMPT   = preempt_q;
   assign bus.ERR       = err_q;

   // Round-robin pick: first active request after the last granted requester
   always_comb begin
      sel   = last_q;
      cand  = '0;
      found = 1'b0;
      for (int unsigned i = 1; i <= NREQ; i++) begin
         cand = OW'((32'(last_q) + i) % NREQ);
         if (!found && req[cand]) begin
            sel   = cand;
            found = 1'b1;
         end
      end
   end

   // Next state and next registered outputs
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      cnt_d     = cnt_q;
      hold_d    = hold_q;
      gnt_d     = gnt_q;
      preempt_d = 1'b0;
      err_d     = 1'b0;
      leave     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (|req) begin
               owner_d = sel;
               hold_d  = 1'b1;
               cnt_d   = '0;
               state_d = S_HOLD_WAIT;
            end
         end
         S_HOLD_WAIT: begin
            cnt_d = cnt_q + CW'(1);
            if (!req[owner_q]) begin
               hold_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_HLDA_WAIT;
            end else if (cnt_q == TO_LAST) begin
               err_d   = 1'b1;
               hold_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_HLDA_WAIT;
            end else if (hlda) begin
               gnt_d          = '0;
               gnt_d[owner_q] = 1'b1;
               cnt_d          = '0;
               last_d         = owner_q;
               preempt_d      = (MAX_BURST == 1);
               state_d        = S_GRANT;
            end
         end
         S_GRANT: begin
            cnt_d = cnt_q + CW'(1);
            if (!hlda) begin
               err_d = 1'b1;
               leave = 1'b1;
            end else if (!req[owner_q] || cnt_q == BURST_LAST) begin
               leave = 1'b1;
            end else begin
               // PREEMPT is registered, so it is raised on the edge that enters the last cycle
               preempt_d = (cnt_d == BURST_LAST);
            end
            if (leave) begin
               gnt_d = '0;
               cnt_d = '0;
               if (TURNAROUND == 0) begin
                  hold_d  = 1'b0;
                  state_d = S_HLDA_WAIT;
               end else begin
                  state_d = S_RELEASE;
               end
            end
         end
         S_RELEASE: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == TA_LAST) begin
               hold_d  = 1'b0;
               cnt_d   = '0;
               state_d = S_HLDA_WAIT;
            end
         end
         S_HLDA_WAIT: begin
            if (!hlda) begin
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; reset clears GNT/HOLD at once
   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state_q   <= S_IDLE;
         owner_q   <= '0;
         last_q    <= OW'(NREQ - 1);
         cnt_q     <= '0;
         hold_q    <= 1'b0;
         gnt_q     <= '0;
         owned_q   <= 1'b0;
         preempt_q <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         hold_q    <= hold_d;
         gnt_q     <= gnt_d;
         owned_q   <= |gnt_d;
         preempt_q <= preempt_d;
         err_q     <= err_d;
      end
   end

   a_gnt_onehot: assert property (@(posedge CLK) disable iff (!RESET_N) $onehot0(gnt_q));
   a_gnt_hold:   assert property (@(posedge CLK) disable iff (!RESET_N)
                                  (|gnt_q) |-> (hold_q && $past(hlda)));
endmodule

// File: tb/tb_bus_hold_arbiter.sv
// Directed bench for bus_hold_arbiter (NREQ=2, MAX_BURST=8, TURNAROUND=1,
// HLDA_TIMEOUT=16). Inputs change and outputs are sampled on the falling edge.
module tb_bus_hold_arbiter;
   localparam int unsigned NREQ = 2;

   logic        CLK     = 1'b0;
   logic        RESET_N = 1'b1;
   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;
   bit          hlda_auto = 1'b0;
   int unsigned dcnt = 0;

   bus_hold_arbiter_if #(.NREQ(NREQ)) bus ();

   bus_hold_arbiter #(
      .NREQ(NREQ),
      .MAX_BURST(8),
      .TURNAROUND(1),
      .HLDA_TIMEOUT(16)
   ) dut (
      .CLK(CLK),
      .RESET_N(RESET_N),
      .bus(bus)
   );

   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   task automatic expect_outs(input string t, input int k, input logic hold,
                              input logic [1:0] gnt, input logic pre, input logic err);
      check($sformatf("%s_hold[%0d]", t, k), 32'(bus.HOLD), 32'(hold));
      check($sformatf("%s_gnt[%0d]", t, k), 32'(bus.GNT), 32'(gnt));
      check($sformatf("%s_owned[%0d]", t, k), 32'(bus.BUS_OWNED), 32'(|gnt));
      check($sformatf("%s_preempt[%0d]", t, k), 32'(bus.PREEMPT), 32'(pre));
      check($sformatf("%s_err[%0d]", t, k), 32'(bus.ERR), 32'(err));
   endtask

   // Processor model: HLDA rises on the 3rd falling edge that sees HOLD, drops when HOLD does
   task automatic cyc();
      @(negedge CLK);
      if (hlda_auto) begin
         if (!bus.HOLD) begin
            bus.HLDA = 1'b0;
            dcnt     = 0;
         end else if (!bus.HLDA) begin
            dcnt++;
            if (dcnt == 3) bus.HLDA = 1'b1;
         end
      end
   endtask

   task automatic do_reset();
      RESET_N  = 1'b0;
      bus.REQ  = '0;
      bus.HLDA = 1'b0;
      dcnt     = 0;
      repeat (2) @(negedge CLK);
      RESET_N  = 1'b1;
   endtask

   initial begin
      bus.REQ  = '0;
      bus.HLDA = 1'b0;
      #1;

      // Reset values
      do_reset();
      expect_outs("rst", 0, 1'b0, 2'b00, 1'b0, 1'b0);

      // Single request, HLDA after 3 cycles, REQ dropped after 4 grant cycles
      hlda_auto = 1'b1;
      bus.REQ   = 2'b01;
      for (int k = 1; k <= 12; k++) begin
         cyc();
         expect_outs("t1", k, (k <= 8) || (k >= 11),
                     (k >= 4 && k <= 7) ? 2'b01 : 2'b00, 1'b0, 1'b0);
         if (k == 7)  bus.REQ = 2'b00;
         if (k == 10) bus.REQ = 2'b10;
      end

      // Both requesting: alternating 8-cycle tenures with PREEMPT in the last cycle
      do_reset();
      hlda_auto = 1'b1;
      bus.REQ   = 2'b11;
      for (int k = 1; k <= 41; k++) begin
         int r;
         logic [1:0] who;
         cyc();
         r   = k % 14;
         who = ((k / 14) % 2 == 0) ? 2'b01 : 2'b10;
         expect_outs("t2", k, (r >= 1 && r <= 12),
                     (r >= 4 && r <= 11) ? who : 2'b00, (r == 11), 1'b0);
      end

      // HLDA never arrives: timeout ERR, HOLD drops, re-request from IDLE
      do_reset();
      hlda_auto = 1'b0;
      bus.REQ   = 2'b10;
      for (int k = 1; k <= 20; k++) begin
         cyc();
         expect_outs("t3", k, (k <= 16) || (k >= 19), 2'b00, 1'b0, (k == 17));
      end

      // Request abandoned before grant (with late HLDA); pending request waits for IDLE
      do_reset();
      hlda_auto = 1'b0;
      bus.REQ   = 2'b01;
      for (int k = 1; k <= 8; k++) begin
         cyc();
         expect_outs("t4", k, (k <= 2) || (k == 8), 2'b00, 1'b0, 1'b0);
         if (k == 2) begin
            bus.REQ  = 2'b00;
            bus.HLDA = 1'b1;
         end
         if (k == 3) bus.REQ  = 2'b10;
         if (k == 6) bus.HLDA = 1'b0;
      end

      // Asynchronous reset mid-grant, then requester 0 wins first
      do_reset();
      hlda_auto = 1'b1;
      bus.REQ   = 2'b10;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         expect_outs("t5", k, 1'b1, (k == 4) ? 2'b10 : 2'b00, 1'b0, 1'b0);
      end
      #2 RESET_N = 1'b0;
      #1;
      check("t5_async_gnt", 32'(bus.GNT), 32'(0));
      check("t5_async_hold", 32'(bus.HOLD), 32'(0));
      check("t5_async_owned", 32'(bus.BUS_OWNED), 32'(0));
      do_reset();
      bus.REQ = 2'b11;
      for (int k = 1; k <= 4; k++) begin
         cyc();
         expect_outs("t5b", k, 1'b1, (k == 4) ? 2'b01 : 2'b00, 1'b0, 1'b0);
      end

      // HLDA dropped during grant: ERR pulse, grant removed, clean return to IDLE
      do_reset();
      hlda_auto = 1'b0;
      bus.REQ   = 2'b01;
      for (int k = 1; k <= 7; k++) begin
         cyc();
         expect_outs("t6", k, (k <= 4) || (k == 7),
                     (k == 2 || k == 3) ? 2'b01 : 2'b00, 1'b0, (k == 4));
         if (k == 1) bus.HLDA = 1'b1;
         if (k == 3) bus.HLDA = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end
endmodule
